// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default line timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DEFAULT_CLK_HZ = 50_000_000;
   localparam int DEFAULT_BAUD   = 9600;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Even mode makes the total count of ones even; odd mode makes it odd.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: strobes bit_end_o on the last clock of every ClocksPerBit-long period.
// A synchronous clear realigns the period to the accept cycle of a new frame.
module uart_baud_gen #(
   parameter int ClocksPerBit = 5208
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_end_o
);

   localparam int CntW = (ClocksPerBit > 2) ? $clog2(ClocksPerBit) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(ClocksPerBit - 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Handshake: a byte transfers on a rising edge where send and ready are both high; send must hold with data_in stable until then.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FrequenciaClock = DEFAULT_CLK_HZ,
   parameter int BaudRate        = DEFAULT_BAUD,
   parameter int ClocksPerBit    = FrequenciaClock / BaudRate,
   parameter int Parity          = PARITY_NONE,
   parameter int StopBits        = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        send,
   output logic        ready,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output uart_state_t dbg_state_o
);

   localparam logic LastStop = (StopBits == 2);

   uart_state_t state_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_cnt_q;
   logic        stop_cnt_q;
   logic        par_q;
   logic        tx_q;
   logic        ready_q;
   logic        done_q;

   logic accept;
   logic bit_end;

   assign accept = (state_q == ST_IDLE) && send && ready_q;

   uart_baud_gen #(
      .ClocksPerBit(ClocksPerBit)
   ) u_baud (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (accept),
      .enable_i (state_q != ST_IDLE),
      .bit_end_o(bit_end)
   );

   // tx is loaded with the next bit's level on the edge that ends the current bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               if (accept) begin
                  shift_q    <= data_in;
                  par_q      <= parity_bit(data_in, Parity);
                  bit_cnt_q  <= '0;
                  stop_cnt_q <= 1'b0;
                  tx_q       <= 1'b0;
                  ready_q    <= 1'b0;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (Parity != PARITY_NONE) begin
                        tx_q    <= par_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (stop_cnt_q == LastStop) begin
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     stop_cnt_q <= 1'b1;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx          = tx_q;
   assign ready       = ready_q;
   assign busy        = ~ready_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances cover no parity / 1 stop, even / 2 stop and odd / 2 stop.
// Drivers push hand-computed frames {stop(s), parity, data, start} into exp_q; per-instance monitors decode tx and pop.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_v [3];
   logic [2:0]  send_v = '0;
   logic [2:0]  ready_v;
   logic [2:0]  tx_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   uart_state_t dbg_v [3];

   logic [11:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cyc [3] = '{-1000, -1000, -1000};
   int gap_v [3] = '{0, 0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.ClocksPerBit(CPB), .Parity(PARITY_NONE), .StopBits(1)) dut0 (
      .clock(clk), .reset(rst_n), .data_in(data_v[0]), .send(send_v[0]), .ready(ready_v[0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .dbg_state_o(dbg_v[0]));

   uart_tx #(.ClocksPerBit(CPB), .Parity(PARITY_EVEN), .StopBits(2)) dut1 (
      .clock(clk), .reset(rst_n), .data_in(data_v[1]), .send(send_v[1]), .ready(ready_v[1]),
      .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .dbg_state_o(dbg_v[1]));

   uart_tx #(.ClocksPerBit(CPB), .Parity(PARITY_ODD), .StopBits(2)) dut2 (
      .clock(clk), .reset(rst_n), .data_in(data_v[2]), .send(send_v[2]), .ready(ready_v[2]),
      .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .dbg_state_o(dbg_v[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: decodes one frame of nbits bits from tx, checks bit stability, length, done and ready timing.
   task automatic monitor(input int idx, input int nbits);
      logic [11:0] frame;
      logic        unstable;
      logic        early_done;
      logic        aborted;
      logic        first;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (tx_v[idx] == 1'b1) begin
            check($sformatf("m%0d idle done low", idx), {31'd0, done_v[idx]}, 32'd0);
            continue;
         end
         check($sformatf("m%0d frame expected", idx), {31'd0, exp_q.size() != 0}, 32'd1);
         check($sformatf("m%0d ready low in frame", idx), {31'd0, ready_v[idx]}, 32'd0);
         check($sformatf("m%0d busy high in frame", idx), {31'd0, busy_v[idx]}, 32'd1);
         gap_v[idx] = cyc - done_cyc[idx];
         frame = '0;
         unstable = 1'b0;
         early_done = 1'b0;
         aborted = 1'b0;
         first = 1'b1;
         for (int b = 0; b < nbits && !aborted; b++) begin
            for (int c = 0; c < CPB; c++) begin
               if (!first) @(negedge clk);
               first = 1'b0;
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (c == 0) frame[b] = tx_v[idx];
               else if (tx_v[idx] !== frame[b]) unstable = 1'b1;
               if (done_v[idx]) early_done = 1'b1;
            end
         end
         if (aborted) continue;
         @(negedge clk);
         check($sformatf("m%0d done at frame end", idx), {31'd0, done_v[idx]}, 32'd1);
         check($sformatf("m%0d ready at frame end", idx), {31'd0, ready_v[idx]}, 32'd1);
         check($sformatf("m%0d busy at frame end", idx), {31'd0, busy_v[idx]}, 32'd0);
         check($sformatf("m%0d bits stable", idx), {31'd0, unstable}, 32'd0);
         check($sformatf("m%0d no early done", idx), {31'd0, early_done}, 32'd0);
         done_cyc[idx] = cyc;
         if (exp_q.size() != 0) check($sformatf("m%0d frame bits", idx), {20'd0, frame}, {20'd0, exp_q.pop_front()});
      end
   endtask

   initial monitor(0, 10);
   initial monitor(1, 12);
   initial monitor(2, 12);

   // Driver: presents a byte, waits for acceptance, checks tx falls the cycle after; hold keeps send high.
   task automatic send_byte(input int idx, input logic [7:0] d, input logic [11:0] exp, input bit hold);
      bit ok;
      @(negedge clk);
      data_v[idx] = d;
      send_v[idx] = 1'b1;
      exp_q.push_back(exp);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ready_v[idx]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("d%0d accepted within bound", idx), {31'd0, ok}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d%0d tx low after accept", idx), {31'd0, tx_v[idx]}, 32'd0);
      if (!hold) send_v[idx] = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset tx %0d", i), {31'd0, tx_v[i]}, 32'd1);
         check($sformatf("reset ready %0d", i), {31'd0, ready_v[i]}, 32'd1);
         check($sformatf("reset busy %0d", i), {31'd0, busy_v[i]}, 32'd0);
         check($sformatf("reset done %0d", i), {31'd0, done_v[i]}, 32'd0);
         check($sformatf("reset state %0d", i), 32'(dbg_v[i]), 32'(ST_IDLE));
      end
      repeat (20) @(negedge clk);
      check("idle tx", {31'd0, tx_v[0]}, 32'd1);
      check("idle ready", {31'd0, ready_v[0]}, 32'd1);

      // Single byte, no parity: 0,1,0,1,0,0,1,0,1,1
      send_byte(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 1'b0);
      wait_drain(200);

      // Even parity, two stops: 0x07 has three ones -> parity 1; 0xFF -> 0
      send_byte(1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 1'b0);
      wait_drain(200);
      send_byte(1, 8'hFF, {2'b11, 1'b0, 8'hFF, 1'b0}, 1'b0);
      wait_drain(200);

      // Odd parity, two stops: 0x07 -> 0; 0x00 -> 1
      send_byte(2, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0}, 1'b0);
      wait_drain(200);
      send_byte(2, 8'h00, {2'b11, 1'b1, 8'h00, 1'b0}, 1'b0);
      wait_drain(200);

      // Back-to-back with send held: one idle clock between frames
      send_byte(0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 1'b1);
      send_byte(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 1'b0);
      wait_drain(200);
      check("back-to-back gap", gap_v[0], 32'd1);

      // Send pulse with 0xFF during a 0x00 frame is ignored
      send_byte(0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 1'b0);
      repeat (10) @(negedge clk);
      data_v[0] = 8'hFF;
      send_v[0] = 1'b1;
      repeat (3) @(negedge clk);
      send_v[0] = 1'b0;
      wait_drain(200);
      repeat (60) @(negedge clk);
      check("no extra frame tx", {31'd0, tx_v[0]}, 32'd1);
      check("no extra frame ready", {31'd0, ready_v[0]}, 32'd1);

      // Reset during data bit 3 of a 0x00 frame
      send_byte(0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 1'b0);
      repeat (16) @(negedge clk);
      check("data bit 3 low", {31'd0, tx_v[0]}, 32'd0);
      check("data bit 3 state", 32'(dbg_v[0]), 32'(ST_DATA));
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset tx", {31'd0, tx_v[0]}, 32'd1);
      check("async reset ready", {31'd0, ready_v[0]}, 32'd1);
      check("async reset busy", {31'd0, busy_v[0]}, 32'd0);
      check("async reset state", 32'(dbg_v[0]), 32'(ST_IDLE));
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post reset ready", {31'd0, ready_v[0]}, 32'd1);
      send_byte(0, 8'h81, {2'b00, 1'b1, 8'h81, 1'b0}, 1'b0);
      wait_drain(200);

      repeat (10) @(negedge clk);
      check("final scoreboard empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
